// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite fabric types, plus the state and response types used by the APB bridge.
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WRESP,
        RRESP
    } apb_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle shared between axi_lite_master and its downstream slaves.
interface axi_lite_if;
    import axi_lite_pkg::*;

    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master, one transaction in flight; all outputs registered.
// Define APB_PSLVERR_EN to map pslverr onto SLVERR responses; otherwise responses are OKAY.
module axi_lite_apb_bridge
    import axi_lite_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    axi_lite_if.slave                 s_axi_lite,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [31:0]               pwdata,
    output logic [3:0]                pstrb,
    input  logic [31:0]               prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    apb_state_t state;
    logic       last_was_write;
    logic       wr_eligible;
    logic       rd_eligible;
    logic       pick_write;
    resp_t      apb_resp;

    assign wr_eligible = s_axi_lite.awvalid && s_axi_lite.wvalid;
    assign rd_eligible = s_axi_lite.arvalid;
    assign pick_write  = wr_eligible && (!rd_eligible || !last_was_write);

`ifdef APB_PSLVERR_EN
    assign apb_resp = pslverr ? RESP_SLVERR : RESP_OKAY;
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr;
    assign apb_resp       = RESP_OKAY;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state              <= IDLE;
            last_was_write     <= 1'b0;
            psel               <= 1'b0;
            penable            <= 1'b0;
            pwrite             <= 1'b0;
            paddr              <= '0;
            pwdata             <= '0;
            pstrb              <= '0;
            s_axi_lite.awready <= 1'b0;
            s_axi_lite.wready  <= 1'b0;
            s_axi_lite.arready <= 1'b0;
            s_axi_lite.bvalid  <= 1'b0;
            s_axi_lite.bresp   <= RESP_OKAY;
            s_axi_lite.rvalid  <= 1'b0;
            s_axi_lite.rresp   <= RESP_OKAY;
            s_axi_lite.rdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Readies are raised one cycle ahead; AXI valids may not drop before
                    // ready, so a raised ready always completes its handshake next edge.
                    if (s_axi_lite.awready) begin
                        s_axi_lite.awready <= 1'b0;
                        s_axi_lite.wready  <= 1'b0;
                        paddr              <= s_axi_lite.awaddr[APB_ADDR_WIDTH-1:0];
                        pwdata             <= s_axi_lite.wdata;
                        pstrb              <= s_axi_lite.wstrb;
                        pwrite             <= 1'b1;
                        last_was_write     <= 1'b1;
                        psel               <= 1'b1;
                        state              <= SETUP;
                    end else if (s_axi_lite.arready) begin
                        s_axi_lite.arready <= 1'b0;
                        paddr              <= s_axi_lite.araddr[APB_ADDR_WIDTH-1:0];
                        pstrb              <= '0;
                        pwrite             <= 1'b0;
                        last_was_write     <= 1'b0;
                        psel               <= 1'b1;
                        state              <= SETUP;
                    end else if (wr_eligible || rd_eligible) begin
                        s_axi_lite.awready <= pick_write;
                        s_axi_lite.wready  <= pick_write;
                        s_axi_lite.arready <= !pick_write;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pwrite) begin
                            s_axi_lite.bvalid <= 1'b1;
                            s_axi_lite.bresp  <= apb_resp;
                            state             <= WRESP;
                        end else begin
                            s_axi_lite.rvalid <= 1'b1;
                            s_axi_lite.rdata  <= prdata;
                            s_axi_lite.rresp  <= apb_resp;
                            state             <= RRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s_axi_lite.bready) begin
                        s_axi_lite.bvalid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                RRESP: begin
                    if (s_axi_lite.rready) begin
                        s_axi_lite.rvalid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed self-checking bench for axi_lite_apb_bridge (honours APB_PSLVERR_EN).
module tb_axi_lite_apb_bridge;

`ifdef APB_PSLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic        aclk;
    logic        areset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_fails  = 0;

    axi_lite_if bus ();

    axi_lite_apb_bridge #(
        .APB_ADDR_WIDTH(32)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .s_axi_lite(bus),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        prdata      = '0;
        pready      = 1'b0;
        pslverr     = 1'b0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        areset_n = 1'b1;
    endtask

    // Full write with bready held high; returns the B response and whether it arrived.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic done);
        done        = 1'b0;
        resp        = 2'b11;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        pready      = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (psel && !penable) begin
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
            end
            if (bus.bvalid) begin
                resp = bus.bresp;
                done = 1'b1;
                break;
            end
        end
        if (done) tick();
        bus.bready = 1'b0;
    endtask

    initial begin : main
        logic [1:0] resp;
        logic       done;
        int         cnt;
        int         starts;
        int         overlaps;
        int         bcnt;
        int         rcnt;
        logic       prev_psel;
        logic       order [2];
        logic [1:0] held_bresp;

        areset_n = 1'b0;
        clear_inputs();
        #12;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_bvalid_bresp", {bus.bvalid, bus.bresp}, 0);
        check("rst_rvalid_rresp", {bus.rvalid, bus.rresp}, 0);
        check("rst_rdata", bus.rdata, 0);
        @(posedge aclk);
        #1;
        areset_n = 1'b1;

        // Write with immediate pready
        bus.awaddr  = 32'h4;
        bus.wdata   = 32'hdeadbeef;
        bus.wstrb   = 4'hf;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        pready      = 1'b1;
        tick();
        check("w1_ready", {bus.awready, bus.wready, bus.arready, psel}, 4'b1100);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("w1_setup", {psel, penable, pwrite, bus.awready}, 4'b1010);
        check("w1_paddr", paddr, 32'h4);
        check("w1_pwdata", pwdata, 32'hdeadbeef);
        check("w1_pstrb", pstrb, 4'hf);
        tick();
        check("w1_access", {psel, penable, bus.bvalid}, 3'b110);
        tick();
        check("w1_bvalid", {psel, penable, bus.bvalid}, 3'b001);
        check("w1_bresp", bus.bresp, 2'b00);
        bus.bready = 1'b1;
        tick();
        check("w1_bdone", bus.bvalid, 0);
        bus.bready = 1'b0;
        pready     = 1'b0;

        // Read with pready delayed three ACCESS cycles
        bus.araddr  = 32'h4;
        bus.arvalid = 1'b1;
        prdata      = 32'hdeadbeef;
        tick();
        check("r1_arready", {bus.arready, bus.awready}, 2'b10);
        tick();
        bus.arvalid = 1'b0;
        check("r1_setup", {psel, penable, pwrite}, 3'b100);
        check("r1_pstrb", pstrb, 4'h0);
        check("r1_paddr", paddr, 32'h4);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rvalid) begin
                done = 1'b1;
                break;
            end
            if (penable) cnt++;
            if (cnt == 4) pready = 1'b1;
        end
        check("r1_rvalid_seen", done, 1);
        check("r1_penable_cycles", cnt, 4);
        check("r1_rdata", bus.rdata, 32'hdeadbeef);
        check("r1_rresp", bus.rresp, 2'b00);
        check("r1_apb_idle", {psel, penable}, 2'b00);
        pready     = 1'b0;
        bus.rready = 1'b1;
        tick();
        check("r1_rdone", bus.rvalid, 0);
        bus.rready = 1'b0;

        // Simultaneous AW/W/AR after reset: write first, then read
        do_reset();
        bus.awaddr  = 32'h10;
        bus.wdata   = 32'h1111;
        bus.wstrb   = 4'h3;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 32'h20;
        bus.arvalid = 1'b1;
        pready      = 1'b1;
        bus.bready  = 1'b1;
        bus.rready  = 1'b1;
        starts      = 0;
        overlaps    = 0;
        bcnt        = 0;
        rcnt        = 0;
        prev_psel   = 1'b0;
        order[0]    = 1'bx;
        order[1]    = 1'bx;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (psel && !penable) begin
                if (starts < 2) order[starts] = pwrite;
                starts++;
                if (prev_psel) overlaps++;
                if (pwrite) begin
                    bus.awvalid = 1'b0;
                    bus.wvalid  = 1'b0;
                end else begin
                    bus.arvalid = 1'b0;
                end
            end
            if (bus.bvalid) bcnt++;
            if (bus.rvalid) rcnt++;
            prev_psel = psel;
        end
        check("tie_transfers", starts, 2);
        check("tie_first_write", order[0], 1);
        check("tie_second_read", order[1], 0);
        check("tie_no_overlap", overlaps, 0);
        check("tie_bcount", bcnt, 1);
        check("tie_rcount", rcnt, 1);
        bus.bready = 1'b0;
        bus.rready = 1'b0;

        // pslverr on a write
        pslverr = 1'b1;
        run_write(32'h30, 32'hcafef00d, 4'hf, resp, done);
        check("err_done", done, 1);
        check("err_bresp", resp, ERR_RESP);
        pslverr = 1'b0;

        // bready held low with an AR queued behind the write
        bus.awaddr  = 32'h40;
        bus.wdata   = 32'h4040;
        bus.wstrb   = 4'hf;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        pready      = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (psel && !penable && pwrite) begin
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                bus.araddr  = 32'h44;
                bus.arvalid = 1'b1;
            end
            if (bus.bvalid) begin
                done = 1'b1;
                break;
            end
        end
        check("bp_bvalid_seen", done, 1);
        held_bresp = bus.bresp;
        check("bp_bresp", held_bresp, 2'b00);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_bvalid", bus.bvalid, 1);
            check("bp_hold_bresp", bus.bresp, held_bresp);
            check("bp_hold_psel_arready", {psel, bus.arready}, 2'b00);
        end
        bus.bready = 1'b1;
        tick();
        check("bp_bdone", {bus.bvalid, bus.arready}, 2'b00);
        bus.bready = 1'b0;
        tick();
        check("bp_ar_accept", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        check("bp_read_setup", {psel, penable, pwrite}, 3'b100);
        check("bp_read_paddr", paddr, 32'h44);
        prdata     = 32'h5a5a_0044;
        bus.rready = 1'b1;
        done       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rvalid) begin
                done = 1'b1;
                break;
            end
        end
        check("bp_rvalid_seen", done, 1);
        check("bp_rdata", bus.rdata, 32'h5a5a_0044);
        tick();
        bus.rready = 1'b0;

        // Reset asserted during ACCESS
        pready      = 1'b0;
        bus.awaddr  = 32'h50;
        bus.wdata   = 32'h5050;
        bus.wstrb   = 4'hf;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (psel && !penable) begin
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
            end
            if (penable) begin
                done = 1'b1;
                break;
            end
        end
        check("rst_mid_access_reached", done, 1);
        areset_n = 1'b0;
        #1;
        check("rst_mid_apb", {psel, penable, pwrite}, 3'b000);
        check("rst_mid_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("rst_mid_bvalid", bus.bvalid, 0);
        check("rst_mid_paddr", paddr, 0);
        pready = 1'b1;
        repeat (2) tick();
        areset_n = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.bvalid || psel) bcnt++;
        end
        check("rst_mid_no_resp", bcnt, 0);
        run_write(32'h54, 32'h12345678, 4'h1, resp, done);
        check("rst_after_done", done, 1);
        check("rst_after_bresp", resp, 2'b00);
        check("idle_hold_paddr", paddr, 32'h54);
        check("idle_hold_pwdata", pwdata, 32'h12345678);
        check("idle_hold_pstrb_pwrite", {pstrb, pwrite}, 5'b0001_1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
